// File: rtl/uart_cmd_wrapper_if.sv
// Handshake bundle between the UART byte transceiver, uart_cmd_wrapper and
// cmd_proc.
//   master : the wrapper side (drives clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data,
//            resp_sent, sync_err, resp_ovf and the two FSM debug states)
//   slave  : the environment side (UART transceiver + cmd_proc)
//
// Handshake semantics:
//   rx_rdy is a level held by the UART until the wrapper returns a one-cycle
//   clr_rx_rdy; cmd_rdy is a sticky valid that holds until clr_cmd_rdy;
//   send_resp, trmt, tx_done, resp_sent, sync_err and resp_ovf are one-cycle
//   pulses.
interface uart_cmd_wrapper_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;
  logic        sync_err;
  logic        resp_ovf;
  // debug: current FSM states (RX: 0=RX_HI 1=RX_LO, TX: 0=TX_IDLE 1=TX_BUSY)
  logic        rx_state;
  logic        tx_state;

  modport master (
    input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, resp_sent, sync_err,
           resp_ovf, rx_state, tx_state
  );

  modport slave (
    output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, trmt, tx_data, resp_sent, sync_err,
           resp_ovf, rx_state, tx_state
  );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// Knight-side glue between the UART byte transceiver and cmd_proc.
//  - RX: pairs two received bytes (high first) into a 16-bit command with a
//    sticky cmd_rdy; an inter-byte timeout drops a lone high byte.
//  - TX: sends response bytes through a 1-entry holding buffer.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : uart_cmd_wrapper_if.master (all handshake/data signals)
module uart_cmd_wrapper #(
  parameter int TIMEOUT_CLKS = 1000000,
  parameter int TO_W         = 20
) (
  input logic               clk,
  input logic               rst_n,
  uart_cmd_wrapper_if.master bus
);

  localparam logic [0:0] RX_HI   = 1'b0;
  localparam logic [0:0] RX_LO   = 1'b1;
  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_BUSY = 1'b1;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CLKS - 1);

  // RX path state
  logic [0:0]      rx_state;
  logic [7:0]      hi_byte;
  logic [TO_W-1:0] to_cnt;
  logic [15:0]     cmd_q;
  logic            cmd_rdy_q;
  logic            clr_rx_q;
  logic            sync_err_q;

  // TX path state
  logic [0:0]      tx_state;
  logic [7:0]      tx_data_q;
  logic            trmt_q;
  logic            resp_sent_q;
  logic            resp_ovf_q;
  logic [7:0]      pend_q;
  logic            pend_vld;

  logic accept;
  logic hi_accept;
  logic lo_accept;
  logic to_hit;

  // A byte is never taken while its own clr_rx_rdy is still in flight, since
  // the UART only drops rx_rdy after seeing that pulse.
  always_comb begin
    accept    = bus.rx_rdy & ~clr_rx_q;
    hi_accept = accept & (rx_state == RX_HI);
    lo_accept = accept & (rx_state == RX_LO);
    to_hit    = (rx_state == RX_LO) & ~accept & (to_cnt == TO_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state   <= RX_HI;
      hi_byte    <= 8'h00;
      to_cnt     <= '0;
      cmd_q      <= 16'h0000;
      cmd_rdy_q  <= 1'b0;
      clr_rx_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      clr_rx_q   <= accept;
      sync_err_q <= to_hit;

      if (hi_accept) begin
        hi_byte  <= bus.rx_data;
        to_cnt   <= '0;
        rx_state <= RX_LO;
      end else if (lo_accept) begin
        cmd_q    <= {hi_byte, bus.rx_data};
        rx_state <= RX_HI;
      end else if (to_hit) begin
        hi_byte  <= 8'h00;
        to_cnt   <= '0;
        rx_state <= RX_HI;
      end else if (rx_state == RX_LO) begin
        to_cnt <= to_cnt + 1'b1;
      end

      // A new command beats a simultaneous acknowledge; a new high byte
      // invalidates whatever command was still waiting.
      if (lo_accept)
        cmd_rdy_q <= 1'b1;
      else if (hi_accept || bus.clr_cmd_rdy)
        cmd_rdy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx_data_q   <= 8'h00;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
      resp_ovf_q  <= 1'b0;
      pend_q      <= 8'h00;
      pend_vld    <= 1'b0;
    end else begin
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
      resp_ovf_q  <= 1'b0;

      case (tx_state)
        TX_IDLE: begin
          if (bus.send_resp) begin
            tx_data_q <= bus.resp;
            trmt_q    <= 1'b1;
            tx_state  <= TX_BUSY;
          end
        end
        default: begin
          if (bus.tx_done) begin
            resp_sent_q <= 1'b1;
            if (pend_vld) begin
              // Pending byte goes out; a coincident request refills the slot.
              tx_data_q <= pend_q;
              trmt_q    <= 1'b1;
              if (bus.send_resp)
                pend_q <= bus.resp;
              else
                pend_vld <= 1'b0;
            end else if (bus.send_resp) begin
              tx_data_q <= bus.resp;
              trmt_q    <= 1'b1;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else if (bus.send_resp) begin
            if (pend_vld) begin
              resp_ovf_q <= 1'b1;
            end else begin
              pend_q   <= bus.resp;
              pend_vld <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.clr_rx_rdy = clr_rx_q;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.trmt       = trmt_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.resp_sent  = resp_sent_q;
  assign bus.resp_ovf   = resp_ovf_q;
  assign bus.rx_state   = rx_state;
  assign bus.tx_state   = tx_state;

endmodule
